// File: rtl/alu_seq_pkg.sv
// Shared types and opcode encodings for the ALU operand sequencer and its flag logic.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_EXEC = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/V derivation from the registered operands, opcode and ALU result.
module alu_flag_calc
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] result,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v
);

   logic sign_a;
   logic sign_b;
   logic sign_r;

   assign sign_a = a[WIDTH-1];
   assign sign_b = b[WIDTH-1];
   assign sign_r = result[WIDTH-1];

   always_comb begin
      n = sign_r;
      z = (result == '0);
      c = 1'b0;
      v = 1'b0;
      case (op)
         // a + b carries out exactly when b exceeds the headroom left above a.
         OP_ADD: begin
            c = (b > ~a);
            v = (sign_a == sign_b) && (sign_r != sign_a);
         end
         OP_SUB: begin
            c = (a < b);
            v = (sign_a != sign_b) && (sign_r != sign_a);
         end
         default: begin
            c = 1'b0;
            v = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A then B+opcode, drives an external combinational ALU, captures result and flags.
module alu_operand_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic [CNT_W-1:0] op_count
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [1:0]       op_q;
   logic             n_q, z_q, c_q, v_q;
   logic [CNT_W-1:0] cnt_q;
   logic             n_w, z_w, c_w, v_w;

   alu_flag_calc #(
      .WIDTH (WIDTH)
   ) u_flags (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_result),
      .n      (n_w),
      .z      (z_w),
      .c      (c_w),
      .v      (v_w)
   );

   // Handshake outputs depend on state only, never on the partner's valid/ready.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         S_A: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_B;
         end
         S_B: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_OUT;
         end
         S_OUT: begin
            res_valid = 1'b1;
            if (res_ready) state_d = S_A;
         end
         default: begin
            state_d = S_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_AND;
         res_q   <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_A && in_valid) begin
            a_q <= in_data;
         end
         if (state_q == S_B && in_valid) begin
            b_q  <= in_data;
            op_q <= in_op;
         end
         if (state_q == S_EXEC) begin
            res_q <= alu_result;
            n_q   <= n_w;
            z_q   <= z_w;
            c_q   <= c_w;
            v_q   <= v_w;
         end
         if (state_q == S_OUT && res_ready) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_control = op_q;
   assign res_data    = res_q;
   assign flag_n      = n_q;
   assign flag_z      = z_q;
   assign flag_c      = c_q;
   assign flag_v      = v_q;
   assign op_count    = cnt_q;

endmodule
